// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per edge; done follows WIDTH+1 edges after start (1 on divide-by-zero).
// No backpressure: start is ignored while busy; results hold until the next operation completes.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [CW-1:0]    count_q, count_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   dvd_ext, dvs_ext, dvd_mag, dvs_mag;
   logic [WIDTH:0]   p_sh, trial;
   logic [WIDTH-1:0] a_sh;
   logic             fits;
   logic             unused_bits;

   // Magnitudes are taken one bit wider so |MIN| is exact before truncation.
   assign dvd_ext = {dividend[WIDTH-1], dividend};
   assign dvs_ext = {divisor[WIDTH-1], divisor};
   assign dvd_mag = dividend[WIDTH-1] ? -dvd_ext : dvd_ext;
   assign dvs_mag = divisor[WIDTH-1] ? -dvs_ext : dvs_ext;

   assign p_sh  = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
   assign a_sh  = {a_q[WIDTH-2:0], 1'b0};
   assign trial = p_sh - {1'b0, b_q};
   assign fits  = (p_sh >= {1'b0, b_q});

   // Restored P never exceeds B, so its top bit and the magnitude MSBs carry no information.
   assign unused_bits = ^{dvd_mag[WIDTH], dvs_mag[WIDTH], p_q[WIDTH]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      count_d = count_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = dvd_mag[WIDTH-1:0];
               b_d     = dvs_mag[WIDTH-1:0];
               qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               rneg_d  = dividend[WIDTH-1];
               p_d     = '0;
               count_d = '0;
               dz_d    = (divisor == '0);
               state_d = (divisor == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            a_d     = {a_sh[WIDTH-1:1], fits};
            p_d     = fits ? trial : p_sh;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // On divide-by-zero A still holds |dividend|, so re-signing it returns the dividend.
            if (dz_q) begin
               quo_d = '1;
               rem_d = rneg_q ? -a_q : a_q;
            end else begin
               quo_d = qneg_q ? -a_q : a_q;
               rem_d = rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            end
            dbz_d   = dz_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         count_q <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         count_q <= count_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
